sc_fetch_unit: RTL and testbench
================================

// Module: sc_fetch_unit
// PURPOSE
//   Instruction fetch stage feeding the single-cycle control unit and datapath.
//   Owns the PC and fetches instructions over a req/ack instruction-memory port.
//   Holds the instruction and presents its op/func fields until the datapath commits it.
//   On commit, applies the control unit's pcsrc selection to form the next PC.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on reset; first fetch address
//   ACK_TIMEOUT  16             max REQ cycles without imem_ack before fault (>=2)
// PORTS
//   clk          in   1   clock; all state updates on the rising edge
//   resetn       in   1   synchronous, active-low reset
//   imem_req     out  1   instruction-memory request, registered
//   imem_addr    out  32  fetch address (== pc), stable while imem_req=1
//   imem_ack     in   1   memory returns imem_rdata this cycle
//   imem_rdata   in   32  instruction word, valid when imem_ack=1
//   inst         out  32  held instruction register
//   op           out  6   inst[31:26], to control unit op
//   func         out  6   inst[5:0], to control unit func
//   inst_valid   out  1   inst/op/func valid; held until commit
//   pc           out  32  address of the held instruction
//   pc_plus4     out  32  pc+4, combinational (jal link value)
//   commit       in   1   datapath has executed the held instruction this cycle
//   pcsrc        in   2   next-PC select from control unit, sampled with commit
//   jr_target    in   32  rs register value for jr, sampled with commit
//   fault        out  1   sticky fetch fault (timeout or misaligned jr target)
// BEHAVIOUR
//   Reset (resetn=0 at an edge): pc=RESET_PC, state=IDLE, imem_req=0, inst=0,
//     inst_valid=0, fault=0, timeout counter=0. Reset wins over every other input,
//     including mid-REQ; an in-flight ack in the reset cycle is discarded.
//   States: IDLE, REQ, HOLD, HALT.
//   IDLE: one cycle after reset; -> REQ, imem_req<=1.
//   REQ: imem_req=1, imem_addr=pc, both stable until ack.
//     imem_ack=1: inst<=imem_rdata, inst_valid<=1, imem_req<=0, counter<=0 -> HOLD.
//     no ack: counter++; when counter==ACK_TIMEOUT-1 and still no ack ->
//       HALT, fault<=1, imem_req<=0. Ack in the timeout cycle wins (-> HOLD).
//     Minimum latency: ack in first REQ cycle -> inst_valid=1 the next cycle.
//   HOLD: inst, pc stable; commit=0 -> stay. commit=1 -> next PC by pcsrc:
//     00: pc+4
//     01: pc+4 + (sext(inst[15:0]) << 2)
//     10: jr_target; if jr_target[1:0]!=0 -> HALT, fault<=1, pc unchanged
//     11: {pc_plus4[31:28], inst[25:0], 2'b00}
//     non-fault commit: pc<=next, inst_valid<=0, imem_req<=1 -> REQ (next fetch
//     issues the cycle after commit).
//   HALT: imem_req=0, inst_valid=0, fault=1; left only by reset.
//   commit outside HOLD and imem_ack outside REQ are ignored.
//   All PC arithmetic 32-bit modulo 2^32 (pc 0xFFFF_FFFC + 4 -> 0x0000_0000).
//   pcsrc/jr_target values are don't-care when commit=0 (x must not propagate).
// TESTING
//   Reset, release -> cycle 1 imem_req=1, imem_addr=0; ack 0x2008_0005 -> next cycle
//     inst_valid=1, op=6'b001000; commit pcsrc=00 -> next REQ imem_addr=0x4.
//   pc=0x10, inst=0x1000_FFFF (beq imm=-1), commit pcsrc=01 -> next imem_addr=0x10.
//   pc=0x1000_0000, inst=0x0800_0040 (j), commit pcsrc=11 -> imem_addr=0x1000_0100.
//   commit pcsrc=10 jr_target=0x200 -> imem_addr=0x200; jr_target=0x103 -> fault=1,
//     imem_req=0, pc unchanged, fault stays 1 until resetn=0.
//   No ack for ACK_TIMEOUT REQ cycles -> fault=1; ack in final cycle -> no fault, HOLD.
//   resetn=0 mid-REQ with simultaneous ack -> inst_valid=0, pc=RESET_PC, refetch 0x0.

Source files
------------

// File: rtl/sc_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack port, holds the
// instruction for the single-cycle datapath and forms the next PC on commit.
module sc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] jr_target,
    output logic        fault
);

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_JR  = 2'b10,
        PC_J   = 2'b11
    } pcsrc_t;

    state_t         state, state_n;
    logic [31:0]    pc_n, inst_n, target;
    logic           inst_valid_n, req_n, fault_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           jr_misaligned;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign op        = inst[31:26];
    assign func      = inst[5:0];

    // Candidate next PC; only consumed when commit=1 in HOLD, so x on pcsrc is harmless.
    always_comb begin
        target = pc_plus4;
        case (pcsrc)
            PC_SEQ:  target = pc_plus4;
            PC_BR:   target = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
            PC_JR:   target = jr_target;
            PC_J:    target = {pc_plus4[31:28], inst[25:0], 2'b00};
            default: target = pc_plus4;
        endcase
    end

    assign jr_misaligned = (jr_target[1:0] != 2'b00);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        inst_valid_n = inst_valid;
        req_n        = imem_req;
        fault_n      = fault;
        cnt_n        = cnt;
        case (state)
            IDLE: begin
                state_n = REQ;
                req_n   = 1'b1;
                cnt_n   = '0;
            end
            REQ: begin
                if (imem_ack) begin
                    inst_n       = imem_rdata;
                    inst_valid_n = 1'b1;
                    req_n        = 1'b0;
                    cnt_n        = '0;
                    state_n      = HOLD;
                end else if (cnt == CNT_LAST) begin
                    fault_n = 1'b1;
                    req_n   = 1'b0;
                    cnt_n   = '0;
                    state_n = HALT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HOLD: begin
                if (commit) begin
                    if (pcsrc == PC_JR && jr_misaligned) begin
                        fault_n      = 1'b1;
                        inst_valid_n = 1'b0;
                        req_n        = 1'b0;
                        state_n      = HALT;
                    end else begin
                        pc_n         = target;
                        inst_valid_n = 1'b0;
                        req_n        = 1'b1;
                        cnt_n        = '0;
                        state_n      = REQ;
                    end
                end
            end
            HALT: begin
                req_n        = 1'b0;
                inst_valid_n = 1'b0;
                fault_n      = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
            fault      <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_valid <= inst_valid_n;
            imem_req   <= req_n;
            fault      <= fault_n;
            cnt        <= cnt_n;
        end
    end

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Directed bench for sc_fetch_unit: hand-computed expectations checked by
// immediate assertions after each clock edge.
module tb_sc_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic [1:0]  pcsrc;
    logic [31:0] jr_target;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    sc_fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .op         (op),
        .func       (func),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .commit     (commit),
        .pcsrc      (pcsrc),
        .jr_target  (jr_target),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    task automatic do_commit(input logic [1:0] sel, input logic [31:0] jr);
        commit    = 1'b1;
        pcsrc     = sel;
        jr_target = jr;
        step();
        commit    = 1'b0;
        pcsrc     = 2'bxx;
        jr_target = 'x;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        resetn     = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        commit     = 1'b0;
        pcsrc      = 2'b00;
        jr_target  = 32'h0;

        // Reset state
        do_reset();
        check("rst_req",   {31'b0, imem_req},   32'd0);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_fault", {31'b0, fault},      32'd0);
        check("rst_pc",    pc,                  32'h0);
        check("rst_inst",  inst,                32'h0);

        // First fetch issues one cycle after release
        step();
        check("f0_req",  {31'b0, imem_req}, 32'd1);
        check("f0_addr", imem_addr,         32'h0);

        // Minimum latency: ack in first REQ cycle
        fetch(32'h2008_0005);
        check("f0_valid", {31'b0, inst_valid}, 32'd1);
        check("f0_op",    {26'b0, op},         32'h08);
        check("f0_func",  {26'b0, func},       32'h05);
        check("f0_inst",  inst,                32'h2008_0005);
        check("f0_req_lo",{31'b0, imem_req},   32'd0);
        check("f0_pc4",   pc_plus4,            32'h4);

        // HOLD with commit=0 and x select inputs: nothing moves
        pcsrc     = 2'bxx;
        jr_target = 'x;
        imem_ack  = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        step();
        imem_ack  = 1'b0;
        check("hold_pc",    pc,                  32'h0);
        check("hold_inst",  inst,                32'h2008_0005);
        check("hold_valid", {31'b0, inst_valid}, 32'd1);

        // Sequential commit
        do_commit(2'b00, 32'h0);
        check("seq_req",   {31'b0, imem_req},   32'd1);
        check("seq_addr",  imem_addr,           32'h4);
        check("seq_valid", {31'b0, inst_valid}, 32'd0);

        // jr to 0x10, then beq with imm=-1 branches back to itself
        fetch(32'h0000_0008);
        do_commit(2'b10, 32'h0000_0010);
        check("jr10_addr", imem_addr, 32'h10);
        fetch(32'h1000_FFFF);
        do_commit(2'b01, 32'h0);
        check("beq_addr", imem_addr, 32'h10);

        // jr to 0x1000_0000, then j
        fetch(32'h0000_0008);
        do_commit(2'b10, 32'h1000_0000);
        check("jr1g_addr", imem_addr, 32'h1000_0000);
        fetch(32'h0800_0040);
        do_commit(2'b11, 32'h0);
        check("j_addr", imem_addr, 32'h1000_0100);

        // Aligned jr
        fetch(32'h0000_0008);
        do_commit(2'b10, 32'h0000_0200);
        check("jr200_addr", imem_addr, 32'h200);

        // Ack arrives in the final allowed REQ cycle: no fault
        repeat (15) step();
        check("late_req",   {31'b0, imem_req}, 32'd1);
        check("late_fault", {31'b0, fault},    32'd0);
        fetch(32'h0000_0008);
        check("late_valid", {31'b0, inst_valid}, 32'd1);
        check("late_nofault", {31'b0, fault},    32'd0);

        // Misaligned jr target: sticky fault, pc unchanged
        do_commit(2'b10, 32'h0000_0103);
        check("mis_fault", {31'b0, fault},      32'd1);
        check("mis_req",   {31'b0, imem_req},   32'd0);
        check("mis_valid", {31'b0, inst_valid}, 32'd0);
        check("mis_pc",    pc,                  32'h200);
        imem_ack = 1'b1;
        do_commit(2'b00, 32'h0);
        step();
        imem_ack = 1'b0;
        check("halt_fault", {31'b0, fault},    32'd1);
        check("halt_pc",    pc,                32'h200);
        check("halt_req",   {31'b0, imem_req}, 32'd0);

        // Full timeout: ACK_TIMEOUT REQ cycles with no ack
        do_reset();
        check("rst2_fault", {31'b0, fault}, 32'd0);
        step();
        check("to_req0", {31'b0, imem_req}, 32'd1);
        repeat (15) step();
        check("to_pre_fault", {31'b0, fault},    32'd0);
        check("to_pre_req",   {31'b0, imem_req}, 32'd1);
        step();
        check("to_fault", {31'b0, fault},    32'd1);
        check("to_req",   {31'b0, imem_req}, 32'd0);

        // PC wrap-around at the top of the address space
        do_reset();
        step();
        fetch(32'h0000_0008);
        do_commit(2'b10, 32'hFFFF_FFFC);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0000);
        check("wrap_pc4", pc_plus4, 32'h0);
        do_commit(2'b00, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // Reset mid-REQ with a simultaneous ack: ack discarded, refetch from RESET_PC
        fetch(32'h0000_0008);
        do_commit(2'b10, 32'h0000_0040);
        check("pre_rst_addr", imem_addr, 32'h40);
        resetn     = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        resetn     = 1'b1;
        check("mrst_valid", {31'b0, inst_valid}, 32'd0);
        check("mrst_pc",    pc,                  32'h0);
        check("mrst_inst",  inst,                32'h0);
        check("mrst_req",   {31'b0, imem_req},   32'd0);
        step();
        check("refetch_req",  {31'b0, imem_req}, 32'd1);
        check("refetch_addr", imem_addr,         32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
